port_a_rx: RTL
==============

PORT_A_RX -- requirements
Module: port_a_rx

Interface
REQ-001 clk  input  1  rising-edge clock for all logic.
REQ-002 rst  input  1  synchronous reset, active-low; sampled on the clk edge.
REQ-003 boot_mode  input  1  high: the current burst carries biases; low: it carries synaptic weights.
REQ-004 port_a_start_out  input  1  one-cycle pulse; word 0 of a burst is valid on dout_a in this same cycle.
REQ-005 port_a_done  input  1  one-cycle pulse marking end of burst.
REQ-006 dout_a  input  32  signed memory read data, one word per cycle during a burst.
REQ-007 burst_id  input  3  neuron index of the burst; sampled only on the cycle where port_a_start_out=1.
REQ-008 sum_out  output  36  signed sum of the 15 weights of the last accepted burst.
REQ-009 sum_id  output  3  neuron index belonging to sum_out.
REQ-010 sum_valid  output  1  sum_out and sum_id are held valid.
REQ-011 sum_ready  input  1  downstream accepts the result when sum_valid=1 and sum_ready=1.
REQ-012 bias_rd_idx  input  3  bias register select.
REQ-013 bias_rd_data  output  32  registered bias read data.
REQ-014 boot_done  output  1  one-cycle pulse when a boot burst completes correctly.
REQ-015 frame_err  output  1  sticky burst-format error flag.
REQ-016 ovf_err  output  1  sticky flag set when a result is dropped because the output register is full.

Function
REQ-017 Burst timing is fixed:
- word 0 arrives with port_a_start_out;
- words 1..14 arrive on the 14 following consecutive cycles;
- port_a_done arrives on the cycle after word 14, which is 15 cycles after start.
REQ-018 States:
- IDLE, RECV, CHECK.
- IDLE->RECV on start.
- RECV->CHECK on done.
- CHECK->IDLE after one cycle.
REQ-019 Word counter (4-bit):
- set to 1 on start;
- increments once per RECV cycle;
- saturates at 15.
REQ-020 Weight mode (boot_mode=0 at start):
- accumulator loads sign-extended word 0 on start;
- each of words 1..14 is sign-extended to 36 bits and added;
- no saturation is needed, because 15 x 2^31 < 2^35.
REQ-021 Boot mode (boot_mode=1 at start):
- word k (k=0..7) is written to bias register k;
- words 8..14 are ignored;
- the accumulator is not updated.
REQ-022 boot_mode is latched at start and the latched value governs the whole burst; changes mid-burst have no effect.
REQ-023 CHECK accepts the burst only if the counter equals 15 when done arrives.
- Otherwise frame_err is set, the result is discarded, and boot_done does not fire.
REQ-024 Done while counter<15 (early done): frame_err set, state goes to IDLE via CHECK.
REQ-025 Counter reaching 15 with no done on the next cycle (late done): frame_err set, state returns to IDLE.
- A later stray done in IDLE is ignored and does not set the flag again.
REQ-026 Start while in RECV: frame_err set; the partial burst is discarded and a new burst restarts from word 0 in the same cycle.
REQ-027 Accepted weight burst while sum_valid=0: on the cycle after CHECK, sum_out is loaded with the accumulator, sum_id with the latched burst_id, and sum_valid is set.
- Latency: done-cycle + 2.
REQ-028 sum_valid clears on the cycle after sum_valid & sum_ready.
- sum_out and sum_id hold their values while sum_valid=1 and sum_ready=0.
REQ-029 Accepted weight burst while sum_valid=1 and no handshake in the same cycle: the new result is dropped and ovf_err is set.
- If the handshake occurs in the same cycle, the new result is loaded and sum_valid stays 1.
REQ-030 Accepted boot burst: boot_done pulses 1 cycle at done-cycle + 2; sum_valid is unaffected.
REQ-031 bias_rd_data equals bias[bias_rd_idx] one cycle after bias_rd_idx is presented.
- Reading and writing the same index in the same cycle returns the old value.
REQ-032 dout_a is ignored outside RECV and outside the start cycle.

Reset
REQ-033 While rst=0:
- state goes to IDLE and the counter and accumulator clear;
- sum_out=0, sum_id=0, sum_valid=0;
- boot_done=0, frame_err=0, ovf_err=0;
- all bias registers=0 and bias_rd_data=0.
REQ-034 Reset asserted mid-burst aborts the burst without flagging an error.
- Data arriving after reset deasserts is ignored until the next start.
REQ-035 frame_err and ovf_err clear only on reset.

Verification
REQ-036 Weight burst, burst_id=3, words 1..15 -> sum_out=120, sum_id=3, sum_valid=1 two cycles after done; hold with sum_ready=0; clear the cycle after sum_ready=1.
REQ-037 15 words of 0x80000000 -> sum_out=-15*2^31 (36'h8_8000_0000 two's complement), no overflow.
REQ-038 Boot burst, words 0x10..0x1E -> boot_done pulse; bias_rd_idx=5 gives 0x15; bias_rd_idx=7 gives 0x17; sum_valid stays 0.
REQ-039 Done after only 10 words -> frame_err=1, no sum_valid; next correct burst still produces a correct sum.
REQ-040 Two weight bursts with sum_ready held 0 -> first result retained, ovf_err=1; repeat with sum_ready=1 during the second CHECK -> second result loaded, ovf_err unchanged.
REQ-041 rst=0 at word 7, then a full burst -> only the new burst's sum appears, frame_err=0.

Source files
------------

// File: rtl/port_a_rx.sv
// Port A burst receiver: sums 15-word weight bursts or loads 8 biases from boot bursts; result at done+2.
// Output register holds under sum_ready=0; a result arriving while it is still full is dropped and flagged.
module port_a_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_mode,
    input  logic        port_a_start_out,
    input  logic        port_a_done,
    input  logic [31:0] dout_a,
    input  logic [2:0]  burst_id,
    output logic [35:0] sum_out,
    output logic [2:0]  sum_id,
    output logic        sum_valid,
    input  logic        sum_ready,
    input  logic [2:0]  bias_rd_idx,
    output logic [31:0] bias_rd_data,
    output logic        boot_done,
    output logic        frame_err,
    output logic        ovf_err
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt;
    logic [35:0] acc;
    logic        mode_q;
    logic [2:0]  id_q;
    logic        chk_ok;
    logic [31:0] bias [8];

    logic        begin_burst;
    logic        take_word;
    logic        end_burst;
    logic        set_ferr;
    logic        cur_mode;
    logic        bias_we;
    logic [2:0]  bias_wa;
    logic [35:0] word_sx;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d     = state;
        begin_burst = 1'b0;
        take_word   = 1'b0;
        end_burst   = 1'b0;
        set_ferr    = 1'b0;
        case (state)
            IDLE: begin
                if (port_a_start_out) begin
                    begin_burst = 1'b1;
                    state_d     = RECV;
                end
            end
            RECV: begin
                // A new start abandons the partial burst and restarts from word 0
                if (port_a_start_out) begin
                    begin_burst = 1'b1;
                    set_ferr    = 1'b1;
                end else if (port_a_done) begin
                    end_burst = 1'b1;
                    set_ferr  = (cnt != 4'd15);
                    state_d   = CHECK;
                end else if (cnt == 4'd15) begin
                    set_ferr = 1'b1;
                    state_d  = IDLE;
                end else begin
                    take_word = 1'b1;
                end
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter value in a RECV cycle is the index of the word on dout_a
    assign cur_mode = begin_burst ? boot_mode : mode_q;
    assign bias_we  = cur_mode && (begin_burst || (take_word && (cnt < 4'd8)));
    assign bias_wa  = begin_burst ? 3'd0 : cnt[2:0];
    assign word_sx  = {{4{dout_a[31]}}, dout_a};

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            acc          <= '0;
            mode_q       <= 1'b0;
            id_q         <= '0;
            chk_ok       <= 1'b0;
            sum_out      <= '0;
            sum_id       <= '0;
            sum_valid    <= 1'b0;
            boot_done    <= 1'b0;
            frame_err    <= 1'b0;
            ovf_err      <= 1'b0;
            bias_rd_data <= '0;
            for (int i = 0; i < 8; i++) bias[i] <= '0;
        end else begin
            boot_done    <= 1'b0;
            bias_rd_data <= bias[bias_rd_idx];

            if (begin_burst) begin
                cnt    <= 4'd1;
                mode_q <= boot_mode;
                id_q   <= burst_id;
                if (!boot_mode) acc <= word_sx;
            end else if (state == RECV && cnt != 4'd15) begin
                cnt <= cnt + 4'd1;
            end

            if (take_word && !mode_q) acc <= acc + word_sx;
            if (bias_we)              bias[bias_wa] <= dout_a;
            if (set_ferr)             frame_err <= 1'b1;
            if (end_burst)            chk_ok <= (cnt == 4'd15);

            if (sum_valid && sum_ready) sum_valid <= 1'b0;

            // A load in the same cycle as a handshake overrides the clear above
            if (state == CHECK && chk_ok) begin
                if (mode_q) begin
                    boot_done <= 1'b1;
                end else if (!sum_valid || sum_ready) begin
                    sum_out   <= acc;
                    sum_id    <= id_q;
                    sum_valid <= 1'b1;
                end else begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

endmodule
